ones_word_gen: RTL and testbench

Bit-serial word generator: the inverse of the block that scans an 8-bit word and reports a 3-bit count of its set bits. Given a 3-bit count and a justification mode, it builds an 8-bit word containing exactly that many ones, one bit per clock, LSB first. It streams each bit as it is generated and presents the finished word with a one-cycle done pulse. It drives the counter's stimulus path and closes the loop for self-checking: the generated word is fed back into the counter, whose count must match.

---
 rtl/ones_word_gen_pkg.sv | 17 +
 rtl/ones_word_gen_if.sv | 25 ++
 rtl/ones_bit_sel.sv | 26 ++
 rtl/ones_word_gen.sv | 112 +++++++++++
 tb/tb_ones_word_gen.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ones_word_gen_pkg.sv
// Shared constants for the ones-word generator and the popcount block it exercises.
// Holds the word/count widths, the FSM state encoding and the justification modes.
package ones_word_gen_pkg;

    localparam int WIDTH = 8;
    localparam int CW    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_LSB = 1'b0;
    localparam logic MODE_MSB = 1'b1;

endpackage

// File: rtl/ones_word_gen_if.sv
// Request/stream/result bundle between a word consumer and the ones-word generator.
// The slave modport is the generator side; the master modport is the requester side.
interface ones_word_gen_if;
    import ones_word_gen_pkg::*;

    logic             start;
    logic [CW-1:0]    count_in;
    logic             mode;
    logic             busy;
    logic             serial_out;
    logic             serial_valid;
    logic [WIDTH-1:0] data_out;
    logic             done;

    modport slave (
        input  start, count_in, mode,
        output busy, serial_out, serial_valid, data_out, done
    );

    modport master (
        output start, count_in, mode,
        input  busy, serial_out, serial_valid, data_out, done
    );

endinterface

// File: rtl/ones_bit_sel.sv
// Justification rule: decides whether bit position idx of the word is a one,
// given the requested count and whether the ones sit at the LSB or MSB end.
module ones_bit_sel
    import ones_word_gen_pkg::*;
(
    input  logic [CW-1:0] idx_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          mode_i,
    output logic          bit_o
);

    // One extra bit so WIDTH - 0 = WIDTH does not wrap and cnt=0 yields no ones.
    localparam logic [CW:0] WIDTH_W = (CW+1)'(WIDTH);

    logic [CW:0] msb_threshold;

    always_comb begin
        msb_threshold = WIDTH_W - {1'b0, cnt_i};
        if (mode_i == MODE_MSB) begin
            bit_o = ({1'b0, idx_i} >= msb_threshold);
        end else begin
            bit_o = (idx_i < cnt_i);
        end
    end

endmodule

// File: rtl/ones_word_gen.sv
// Bit-serial generator of an 8-bit word holding exactly cnt ones, LSB first,
// streaming each bit and presenting the finished word with a one-cycle done pulse.
module ones_word_gen
    import ones_word_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ones_word_gen_if.slave    bus
);

    state_e           state_q;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q;
    logic             mode_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] data_q;
    logic             busy_q;
    logic             sout_q;
    logic             svalid_q;
    logic             done_q;

    logic [CW-1:0]    sel_idx;
    logic [CW-1:0]    sel_cnt;
    logic             sel_mode;
    logic             sel_bit;
    logic [WIDTH-1:0] shreg_d;

    // The selector looks one bit ahead so serial_out can be a register: in IDLE it
    // evaluates bit 0 of the incoming request, in BUILD the bit of the next cycle.
    always_comb begin
        sel_idx  = idx_q + 1'b1;
        sel_cnt  = cnt_q;
        sel_mode = mode_q;
        if (state_q == IDLE) begin
            sel_idx  = '0;
            sel_cnt  = bus.count_in;
            sel_mode = bus.mode;
        end
        shreg_d = {sout_q, shreg_q[WIDTH-1:1]};
    end

    ones_bit_sel u_bit_sel (
        .idx_i  (sel_idx),
        .cnt_i  (sel_cnt),
        .mode_i (sel_mode),
        .bit_o  (sel_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_LSB;
            shreg_q  <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            sout_q   <= 1'b0;
            svalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        cnt_q    <= bus.count_in;
                        mode_q   <= bus.mode;
                        idx_q    <= '0;
                        shreg_q  <= '0;
                        busy_q   <= 1'b1;
                        svalid_q <= 1'b1;
                        sout_q   <= sel_bit;
                        state_q  <= BUILD;
                    end
                end
                BUILD: begin
                    shreg_q <= shreg_d;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == CW'(WIDTH - 1)) begin
                        // Final shift goes straight to data_out so done and the word coincide.
                        data_q   <= shreg_d;
                        done_q   <= 1'b1;
                        svalid_q <= 1'b0;
                        sout_q   <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        sout_q <= sel_bit;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    svalid_q <= 1'b0;
                    sout_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.serial_out   = sout_q;
    assign bus.serial_valid = svalid_q;
    assign bus.data_out     = data_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_ones_word_gen.sv
// Self-checking bench for ones_word_gen: directed cases plus randomized builds,
// checked against an arithmetic word model and a popcount loopback.
module tb_ones_word_gen;
    import ones_word_gen_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    ones_word_gen_if bus ();

    ones_word_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_word(input int c, input int m);
        int ones;
        ones = (1 << c) - 1;
        if (m != 0) return 8'(ones << (8 - c));
        return 8'(ones);
    endfunction

    function automatic int popcount(input logic [7:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(w[i]);
        return n;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},   32'(bus.busy), 0);
        check_eq({tag, "_sout"},   32'(bus.serial_out), 0);
        check_eq({tag, "_svalid"}, 32'(bus.serial_valid), 0);
        check_eq({tag, "_done"},   32'(bus.done), 0);
        check_eq({tag, "_data"},   32'(bus.data_out), 0);
    endtask

    // One full build; glitch_k >= 0 pulses start (count 1) in that BUILD cycle,
    // poke_done raises start during the DONE cycle. Both must be ignored.
    task automatic run_build(input int c, input int m, input int glitch_k, input bit poke_done);
        logic [7:0] w;
        w = exp_word(c, m);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.count_in = 3'(c);
        bus.mode     = m[0];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == glitch_k) begin
                bus.start    = 1'b1;
                bus.count_in = 3'd1;
            end else begin
                bus.start    = 1'b0;
                bus.count_in = 3'($urandom);
            end
            bus.mode = 1'($urandom);
            check_eq($sformatf("svalid[%0d]", k), 32'(bus.serial_valid), 1);
            check_eq($sformatf("busy[%0d]", k),   32'(bus.busy), 1);
            check_eq($sformatf("sout[%0d]", k),   32'(bus.serial_out), 32'(w[k]));
            check_eq($sformatf("nodone[%0d]", k), 32'(bus.done), 0);
        end
        @(negedge clk);
        bus.start = poke_done;
        check_eq("done_pulse",  32'(bus.done), 1);
        check_eq("done_word",   32'(bus.data_out), 32'(w));
        check_eq("done_svalid", 32'(bus.serial_valid), 0);
        check_eq("done_busy",   32'(bus.busy), 1);
        check_eq("loop_count",  32'(popcount(bus.data_out)), 32'(c));
        $display("build count=%0d mode=%0d glitch=%0d poke=%0d word=%b", c, m, glitch_k, poke_done, bus.data_out);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("post_done",  32'(bus.done), 0);
        check_eq("post_busy",  32'(bus.busy), 0);
        check_eq("post_hold",  32'(bus.data_out), 32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int t1;
        bit seen;
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.count_in = '0;
        bus.mode     = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle");

        run_build(4, 0, -1, 1'b0);
        run_build(7, 1, -1, 1'b0);
        run_build(0, 0, -1, 1'b0);
        run_build(0, 1, -1, 1'b0);
        run_build(6, 0, 3, 1'b1);
        run_build(3, 1, 3, 1'b1);

        // Abort with reset in BUILD cycle 4.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.count_in = 3'd5;
        bus.mode     = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check_eq("abort_nodone", 32'(seen), 0);
        $display("reset abort during build");
        rst = 1'b1;
        run_build(2, 0, -1, 1'b0);

        // start held high: back-to-back builds.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.count_in = 3'd3;
        bus.mode     = 1'b0;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 40 && t1 < 0; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (t0 < 0) t0 = cyc;
                else t1 = cyc;
            end
        end
        bus.start = 1'b0;
        check_eq("b2b_seen",    32'(t1 >= 0), 1);
        check_eq("b2b_spacing", 32'(t1 - t0), 10);
        check_eq("b2b_word",    32'(bus.data_out), 32'(exp_word(3, 0)));
        $display("back-to-back builds spacing=%0d", t1 - t0);
        repeat (12) @(negedge clk);
        check_eq("b2b_idle", 32'(bus.busy), 0);

        // Loopback sweep of every (count, mode) pair.
        for (int i = 0; i < 16; i++) run_build(i >> 1, i & 1, -1, 1'b0);

        // Randomized builds with optional ignored start pulses.
        for (int i = 0; i < 24; i++) begin
            run_build(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 8)) - 1, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
